// File: rtl/button_debouncer.sv
// Pushbutton debouncer: two-flop synchronizer feeding a four-state qualify FSM.
// button_OUT is active-low and only moves after DB_CYCLES stable synchronized samples.
module button_debouncer #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_OUT,
  output logic busy
);

  typedef enum logic [1:0] {
    REL  = 2'd0,
    PCHK = 2'd1,
    PRS  = 2'd2,
    RCHK = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;

  // Next-state logic; busy is derived from the next state so it stays in step with state_q.
  always_comb begin
    sync1_d = button_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      REL: begin
        if (!sync2_q) begin
          state_d = PCHK;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = REL;
        end
      end
      PCHK: begin
        if (sync2_q) begin
          state_d = REL;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS;
          cnt_d   = CNT_ZERO;
          out_d   = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRS: begin
        if (sync2_q) begin
          state_d = RCHK;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = PRS;
        end
      end
      RCHK: begin
        if (!sync2_q) begin
          state_d = PRS;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REL;
          cnt_d   = CNT_ZERO;
          out_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = CNT_ZERO;
        out_d   = 1'b1;
      end
    endcase
    busy_d = (state_d == PCHK) || (state_d == RCHK);
  end

  // State, counter, synchronizer and output registers; reset forces the released idle state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= REL;
      cnt_q   <= CNT_ZERO;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign button_OUT = out_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (DB_CYCLES=4): stimulus queues expected
// output/busy change events with their edge number; the monitor pops on every change.
module tb_button_debouncer;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic button_raw = 1'b0;
  logic button_OUT;
  logic busy;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   kind;     // 0 = button_OUT, 1 = busy
    logic val;
    int   edge_no;
  } evt_t;
  evt_t exp_q[$];

  // Behavioural stand-in for the downstream pulse shaper (falling edge of button_OUT).
  logic shaper_en    = 1'b1;
  logic out_prev     = 1'b1;
  logic pulse_q      = 1'b0;
  logic pulse_seen   = 1'b0;
  int   pulse_cycles = 0;
  int   pulse_starts = 0;

  logic prev_out  = 1'b1;
  logic prev_busy = 1'b0;

  int c;
  int r;
  int p0;
  int blen [10] = '{1, 2, 3, 3, 2, 1, 1, 2, 3, 2};

  button_debouncer #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .button_raw (button_raw),
    .button_OUT (button_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    out_prev <= button_OUT;
    pulse_q  <= shaper_en & out_prev & ~button_OUT;
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic push(input int kind, input logic val, input int edge_no);
    evt_t e;
    e.kind    = kind;
    e.val     = val;
    e.edge_no = edge_no;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int kind, input logic val);
    evt_t  e;
    string nm;
    nm = (kind == 0) ? "button_OUT" : "busy";
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: changed to %0b at edge %0d, required no change", nm, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.edge_no != cyc) begin
        n_fail++;
        $display("FAIL event_%s: got %0b at edge %0d, expected %s=%0b at edge %0d",
                 nm, val, cyc, (e.kind == 0) ? "button_OUT" : "busy", e.val, e.edge_no);
      end
    end
  endtask

  task automatic drain(input string nm);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 60) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d events pending after %0d cycles, expected 0", nm, exp_q.size(), b);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Monitor: samples 2 time units after each rising edge and scores every output change.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        if (button_OUT !== prev_out) check_evt(0, button_OUT);
        if (busy !== prev_busy)      check_evt(1, busy);
      end
      prev_out  = button_OUT;
      prev_busy = busy;
      if (pulse_q) begin
        pulse_cycles++;
        if (!pulse_seen) pulse_starts++;
      end
      pulse_seen = pulse_q;
    end
  end

  initial begin
    // Reset with the button pressed: outputs must respond before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("reset_async_out", button_OUT, 1);
    chk("reset_async_busy", busy, 0);
    button_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press.
    c = cyc;
    button_raw = 1'b0;
    push(1, 1'b1, c + 3);
    push(0, 1'b0, c + 7);
    push(1, 1'b0, c + 7);
    drain("clean_press");
    chk("press_one_pulse", pulse_starts, 1);

    // Release with a 2-cycle low glitch mid-qualification, then a clean release.
    c = cyc;
    button_raw = 1'b1;
    push(1, 1'b1, c + 3);
    push(1, 1'b0, c + 6);
    push(1, 1'b1, c + 8);
    push(0, 1'b1, c + 12);
    push(1, 1'b0, c + 12);
    repeat (3) @(negedge clk);
    button_raw = 1'b0;
    repeat (2) @(negedge clk);
    button_raw = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_out_held", button_OUT, 0);
    chk("glitch_back_to_prs", busy, 0);
    drain("release_glitch");

    // Bounce during press qualification.
    c = cyc;
    button_raw = 1'b0;
    push(1, 1'b1, c + 3);
    push(1, 1'b0, c + 6);
    push(1, 1'b1, c + 7);
    push(0, 1'b0, c + 11);
    push(1, 1'b0, c + 11);
    repeat (3) @(negedge clk);
    button_raw = 1'b1;
    @(negedge clk);
    button_raw = 1'b0;
    drain("bounce_press");

    // Reset while pressed; button held through reset re-qualifies after release.
    rst = 1'b0;
    #1;
    chk("reset_prs_out", button_OUT, 1);
    chk("reset_prs_busy", busy, 0);
    repeat (2) @(negedge clk);
    r = cyc;
    rst = 1'b1;
    push(1, 1'b1, r + 3);
    push(0, 1'b0, r + 7);
    push(1, 1'b0, r + 7);
    drain("held_through_reset");

    // Clean release.
    c = cyc;
    button_raw = 1'b1;
    push(1, 1'b1, c + 3);
    push(0, 1'b1, c + 7);
    push(1, 1'b0, c + 7);
    drain("clean_release");

    // Reset mid press-candidate with cnt=2.
    c = cyc;
    button_raw = 1'b0;
    push(1, 1'b1, c + 3);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_pchk_busy", busy, 0);
    chk("reset_pchk_out", button_OUT, 1);
    @(negedge clk);
    r = cyc;
    rst = 1'b1;
    push(1, 1'b1, r + 3);
    push(0, 1'b0, r + 7);
    push(1, 1'b0, r + 7);
    drain("reset_mid_pchk");

    c = cyc;
    button_raw = 1'b1;
    push(1, 1'b1, c + 3);
    push(0, 1'b1, c + 7);
    push(1, 1'b0, c + 7);
    drain("release_again");

    // Ten short bounces from released: candidate opens and closes, no output change.
    p0 = pulse_starts;
    for (int i = 0; i < 10; i++) begin
      c = cyc;
      button_raw = 1'b0;
      push(1, 1'b1, c + 3);
      push(1, 1'b0, c + 3 + blen[i]);
      repeat (blen[i]) @(negedge clk);
      button_raw = 1'b1;
      repeat (4) @(negedge clk);
    end
    drain("short_bounces");
    chk("bounces_no_pulse", pulse_starts, p0);
    chk("bounces_out_released", button_OUT, 1);

    chk("total_presses", pulse_starts, 4);
    chk("pulse_single_cycle", pulse_cycles, pulse_starts);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DB_CYCLES, default 500000, SHALL be the number of consecutive stable synchronized samples that qualify a level change (10 ms at 50 MHz); legal range 2..(2^CNT_W)-1.
REQ-002 Parameter CNT_W, default 20, SHALL be the debounce counter width in bits.
REQ-003 clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 button_raw  input  1  SHALL be the asynchronous, bouncing pushbutton pin, active-low (0 = pressed, 1 = released).
REQ-006 button_OUT  output  1  SHALL be the debounced button level, active-low (0 = pressed, 1 = released), registered; it feeds the downstream pulse shaper's button input directly.
REQ-007 busy  output  1  SHALL be high while a candidate level change is being qualified, registered.

Function
REQ-008 The block SHALL pass button_raw through a two-flop synchronizer (sync1, then sync2); only sync2 SHALL be used by the FSM.
REQ-009 The FSM SHALL have exactly four states, 2-bit encoded: REL=0 (stable released), PCHK=1 (press candidate), PRS=2 (stable pressed), RCHK=3 (release candidate).
REQ-010 In REL, sync2==0 SHALL move to PCHK with cnt cleared to 0; otherwise the FSM SHALL remain in REL.
REQ-011 In PCHK, sync2==1 SHALL return to REL with cnt cleared (bounce rejected, button_OUT unchanged).
REQ-012 In PCHK with sync2==0, cnt SHALL increment by 1 when cnt != DB_CYCLES-1, and SHALL move to PRS with button_OUT<=0 and cnt<=0 when cnt == DB_CYCLES-1.
REQ-013 In PRS, sync2==1 SHALL move to RCHK with cnt cleared; otherwise the FSM SHALL remain in PRS.
REQ-014 In RCHK, sync2==0 SHALL return to PRS with cnt cleared (bounce rejected, button_OUT unchanged).
REQ-015 In RCHK with sync2==1, cnt SHALL increment when cnt != DB_CYCLES-1, and SHALL move to REL with button_OUT<=1 and cnt<=0 when cnt == DB_CYCLES-1.
REQ-016 The counter SHALL never wrap; it SHALL be compared against DB_CYCLES-1 only, truncated to CNT_W bits.
REQ-017 button_OUT SHALL change only on the REQ-012 and REQ-015 transitions and SHALL never glitch.
REQ-018 busy SHALL be 1 exactly while the state is PCHK or RCHK, and SHALL be registered alongside the state.
REQ-019 Latency: for a clean level held from rising edge E1 (the first edge to sample it), button_OUT SHALL change on edge E1+DB_CYCLES+2, i.e. the (DB_CYCLES+3)th edge counting E1 as 1.
REQ-020 A bounce of any width shorter than DB_CYCLES synchronized cycles SHALL restart qualification from cnt=0 and SHALL leave button_OUT unchanged.
REQ-021 An illegal state value SHALL return to REL with button_OUT<=1, busy<=0, cnt<=0 on the next edge.

Reset
REQ-022 While rst==0, the block SHALL asynchronously force sync1=1, sync2=1, state=REL, cnt=0, button_OUT=1, busy=0, independent of clk.
REQ-023 Reset asserted mid-qualification (PCHK or RCHK) SHALL abandon the candidate, and after release the block SHALL re-qualify from REL.
REQ-024 After rst deasserts, the first state update SHALL occur on the first rising edge; a button held pressed through reset SHALL produce button_OUT=0 on edge DB_CYCLES+3 after release.

Verification (DB_CYCLES=4, CNT_W=3)
REQ-025 Reset: assert rst=0 with button_raw=0 -> button_OUT=1 and busy=0 immediately, with no clk edge required.
REQ-026 Clean press: button_raw 1->0 held -> busy=1 from edge 3; button_OUT=0 on edge 7; busy=0 on edge 7.
REQ-027 Bounce reject: raw low for 3 cycles, then high 1 cycle, then low held -> no output change during the bounce; button_OUT=0 exactly 7 edges after the final falling sample.
REQ-028 Clean release from PRS: raw 0->1 held -> button_OUT=1 on edge 7; a 2-cycle low glitch mid-RCHK returns the FSM to PRS with button_OUT still 0.
REQ-029 Reset mid-PCHK: rst pulsed low with cnt=2 -> state REL and cnt 0; raw still low -> button_OUT=0 on edge 7 after release.
REQ-030 Downstream integration: connect to the pulse shaper with its control flag high; one clean press -> exactly one single-cycle pulse from the shaper, and 10 bounces shorter than 4 cycles -> no pulse.
